// File: rtl/router_output_channel.sv
// router_output_channel: transmit side of a mesh router link.
// Two polarity-keyed virtual channel FIFOs (VC0 even, VC1 odd) feed the link;
// the VC selected by polarity is offered each cycle and popped on ready_in.
module router_output_channel #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        polarity,
    input  logic        wr_en,
    input  logic        wr_vc,
    input  logic [63:0] wr_data,
    input  logic        ready_in,
    output logic        send_out,
    output logic [63:0] data_out,
    output logic [1:0]  vc_full,
    output logic [1:0]  vc_empty,
    output logic        overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] ZERO_CNT = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_CNT  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] ONE_PTR  = {{(AW-1){1'b0}}, 1'b1};

    logic [63:0]   mem_r [2][DEPTH];
    logic [AW-1:0] wr_ptr_r [2];
    logic [AW-1:0] rd_ptr_r [2];
    logic [CW-1:0] count_r [2];
    logic [1:0]    vc_full_r;
    logic [1:0]    vc_empty_r;
    logic          overflow_r;

    logic [1:0]    wr_accept_s;
    logic [1:0]    pop_s;
    logic [CW-1:0] count_nxt_s [2];
    logic          send_s;
    logic [63:0]   data_s;

    // Link offer: head of the polarity-selected VC, zeroed when that VC is empty.
    always_comb begin
        send_s = !vc_empty_r[polarity];
        data_s = 64'h0;
        if (send_s) begin
            data_s = mem_r[polarity][rd_ptr_r[polarity]];
        end else begin
            data_s = 64'h0;
        end
    end

    // Accept/pop decisions and next counts; full check uses the registered flag
    // so a same-edge pop never makes room for a write to a full VC.
    always_comb begin
        wr_accept_s = 2'b00;
        pop_s       = 2'b00;
        if (wr_en && !vc_full_r[wr_vc]) begin
            wr_accept_s[wr_vc] = 1'b1;
        end else begin
            wr_accept_s = 2'b00;
        end
        if (send_s && ready_in) begin
            pop_s[polarity] = 1'b1;
        end else begin
            pop_s = 2'b00;
        end
        for (int v = 0; v < 2; v++) begin
            case ({wr_accept_s[v], pop_s[v]})
                2'b10:   count_nxt_s[v] = count_r[v] + ONE_CNT;
                2'b01:   count_nxt_s[v] = count_r[v] - ONE_CNT;
                default: count_nxt_s[v] = count_r[v];
            endcase
        end
    end

    // Pointer, count, status flag and sticky overflow registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int v = 0; v < 2; v++) begin
                wr_ptr_r[v] <= {AW{1'b0}};
                rd_ptr_r[v] <= {AW{1'b0}};
                count_r[v]  <= ZERO_CNT;
            end
            vc_full_r  <= 2'b00;
            vc_empty_r <= 2'b11;
            overflow_r <= 1'b0;
        end else begin
            for (int v = 0; v < 2; v++) begin
                if (wr_accept_s[v]) begin
                    wr_ptr_r[v] <= wr_ptr_r[v] + ONE_PTR;
                end
                if (pop_s[v]) begin
                    rd_ptr_r[v] <= rd_ptr_r[v] + ONE_PTR;
                end
                count_r[v]    <= count_nxt_s[v];
                vc_full_r[v]  <= (count_nxt_s[v] == FULL_CNT);
                vc_empty_r[v] <= (count_nxt_s[v] == ZERO_CNT);
            end
            if (wr_en && vc_full_r[wr_vc]) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Flit storage; contents need no reset because pointers/counts gate visibility.
    always_ff @(posedge clk) begin
        for (int v = 0; v < 2; v++) begin
            if (!reset && wr_accept_s[v]) begin
                mem_r[v][wr_ptr_r[v]] <= wr_data;
            end
        end
    end

    assign send_out = send_s;
    assign data_out = data_s;
    assign vc_full  = vc_full_r;
    assign vc_empty = vc_empty_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_router_output_channel.sv
// Self-checking bench for router_output_channel: queue-based reference model,
// directed scenarios plus a randomized interleaved stream.
module tb_router_output_channel;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        polarity;
    logic        wr_en;
    logic        wr_vc;
    logic [63:0] wr_data;
    logic        ready_in;
    logic        send_out;
    logic [63:0] data_out;
    logic [1:0]  vc_full;
    logic [1:0]  vc_empty;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] mq0[$];
    logic [63:0] mq1[$];
    bit          m_ovf;

    router_output_channel #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .polarity(polarity), .wr_en(wr_en),
        .wr_vc(wr_vc), .wr_data(wr_data), .ready_in(ready_in),
        .send_out(send_out), .data_out(data_out), .vc_full(vc_full),
        .vc_empty(vc_empty), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic int msize(input logic v);
        return v ? mq1.size() : mq0.size();
    endfunction

    function automatic logic [63:0] mhead(input logic v);
        if (v) return (mq1.size() != 0) ? mq1[0] : 64'h0;
        return (mq0.size() != 0) ? mq0[0] : 64'h0;
    endfunction

    // Apply inputs just after a rising edge and move to the falling edge for sampling.
    task automatic drive(input logic r, input logic p, input logic we, input logic wv,
                         input logic [63:0] wd, input logic rdy);
        reset = r; polarity = p; wr_en = we; wr_vc = wv; wr_data = wd; ready_in = rdy;
        @(negedge clk);
    endtask

    // Advance to the rising edge and apply the same edge to the reference model.
    task automatic commit();
        bit send_p;
        int sz_w;
        @(posedge clk);
        if (reset) begin
            mq0.delete(); mq1.delete(); m_ovf = 1'b0;
        end else begin
            send_p = (msize(polarity) != 0);
            sz_w   = msize(wr_vc);
            if (send_p && ready_in) begin
                if (polarity) void'(mq1.pop_front());
                else          void'(mq0.pop_front());
            end
            if (wr_en) begin
                if (sz_w >= DEPTH) m_ovf = 1'b1;
                else if (wr_vc)    mq1.push_back(wr_data);
                else               mq0.push_back(wr_data);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 64'hDEAD, 1'b1); commit();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 64'hBEEF, 1'b1); commit();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
        n_checks++; if (send_out !== 1'b0) begin n_fail++; $display("FAIL reset_send: got %b expected 0", send_out); end
        n_checks++; if (data_out !== 64'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", data_out); end
        n_checks++; if (vc_empty !== 2'b11) begin n_fail++; $display("FAIL reset_empty: got %b expected 11", vc_empty); end
        n_checks++; if (vc_full !== 2'b00) begin n_fail++; $display("FAIL reset_full: got %b expected 00", vc_full); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
        commit();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
        n_checks++; if (send_out !== 1'b0) begin n_fail++; $display("FAIL reset_send_odd: got %b expected 0", send_out); end
        commit();
    endtask

    task automatic test_single_flit();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 64'hA5, 1'b0); commit();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
        n_checks++; if (send_out !== 1'b1) begin n_fail++; $display("FAIL single_send: got %b expected 1", send_out); end
        n_checks++; if (data_out !== 64'hA5) begin n_fail++; $display("FAIL single_data: got %h expected a5", data_out); end
        commit();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
        n_checks++; if (vc_empty[0] !== 1'b1) begin n_fail++; $display("FAIL single_empty: got %b expected 1", vc_empty[0]); end
        commit();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
        n_checks++; if (send_out !== 1'b0 || data_out !== 64'h0) begin n_fail++; $display("FAIL single_gone: got %b/%h expected 0/0", send_out, data_out); end
        commit();
    endtask

    task automatic test_backpressure();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 64'h1, 1'b0); commit();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
            n_checks++; if (send_out !== 1'b1 || data_out !== 64'h1) begin n_fail++; $display("FAIL bp_hold%0d: got %b/%h expected 1/1", i, send_out, data_out); end
            commit();
            drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
            n_checks++; if (send_out !== 1'b0 || data_out !== 64'h0) begin n_fail++; $display("FAIL bp_even%0d: got %b/%h expected 0/0", i, send_out, data_out); end
            commit();
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b1);
        n_checks++; if (data_out !== 64'h1) begin n_fail++; $display("FAIL bp_release: got %h expected 1", data_out); end
        commit();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
        n_checks++; if (vc_empty[1] !== 1'b1) begin n_fail++; $display("FAIL bp_popped: got %b expected 1", vc_empty[1]); end
        commit();
    endtask

    task automatic test_overflow();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 64'h1, 1'b0); commit();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 64'h2, 1'b0); commit();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
        n_checks++; if (vc_full[1] !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got %b expected 1", vc_full[1]); end
        commit();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 64'h3, 1'b1);
        n_checks++; if (data_out !== 64'h1) begin n_fail++; $display("FAIL ovf_head1: got %h expected 1", data_out); end
        commit();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b1);
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        n_checks++; if (data_out !== 64'h2) begin n_fail++; $display("FAIL ovf_head2: got %h expected 2", data_out); end
        commit();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b1);
        n_checks++; if (send_out !== 1'b0 || data_out !== 64'h0) begin n_fail++; $display("FAIL ovf_no3: got %b/%h expected 0/0", send_out, data_out); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
        commit();
    endtask

    task automatic test_interleave_wrap();
        logic [63:0] tx0[$], tx1[$], rx0[$], rx1[$];
        int s0 = 0, s1 = 0;
        bit done = 1'b0;
        logic p, we, wv, rdy;
        logic [63:0] wd;
        for (int i = 0; i < 6; i++) begin
            tx0.push_back({$urandom(), $urandom()});
            tx1.push_back({$urandom(), $urandom()});
        end
        tx0[2] = 64'h0;
        for (int c = 0; c < 400 && !done; c++) begin
            p = c[0]; rdy = ($urandom_range(0, 3) != 0); we = 1'b0; wv = 1'b0; wd = 64'h0;
            wv = $urandom_range(0, 1);
            if (!(wv ? (s1 < 6 && msize(1'b1) < DEPTH) : (s0 < 6 && msize(1'b0) < DEPTH))) wv = ~wv;
            if (wv ? (s1 < 6 && msize(1'b1) < DEPTH) : (s0 < 6 && msize(1'b0) < DEPTH)) begin
                we = ($urandom_range(0, 3) != 0);
                wd = wv ? tx1[s1] : tx0[s0];
            end
            drive(1'b0, p, we, wv, wd, rdy);
            n_checks++; if (send_out !== (msize(p) != 0)) begin n_fail++; $display("FAIL il_send c%0d: got %b expected %b", c, send_out, msize(p) != 0); end
            n_checks++; if (data_out !== mhead(p)) begin n_fail++; $display("FAIL il_data c%0d: got %h expected %h", c, data_out, mhead(p)); end
            n_checks++; if (vc_empty !== {msize(1'b1) == 0, msize(1'b0) == 0}) begin n_fail++; $display("FAIL il_empty c%0d: got %b", c, vc_empty); end
            n_checks++; if (vc_full !== {msize(1'b1) >= DEPTH, msize(1'b0) >= DEPTH}) begin n_fail++; $display("FAIL il_full c%0d: got %b", c, vc_full); end
            if (send_out === 1'b1 && rdy) begin
                if (p) rx1.push_back(data_out); else rx0.push_back(data_out);
            end
            if (we) begin
                if (wv) s1++; else s0++;
            end
            commit();
            done = (s0 == 6) && (s1 == 6) && (mq0.size() == 0) && (mq1.size() == 0);
        end
        n_checks++; if (!done) begin n_fail++; $display("FAIL il_timeout: got sent %0d/%0d expected 6/6 drained", s0, s1); end
        n_checks++; if (rx0.size() != 6 || rx1.size() != 6) begin n_fail++; $display("FAIL il_count: got %0d/%0d expected 6/6", rx0.size(), rx1.size()); end
        for (int i = 0; i < 6; i++) begin
            if (i < rx0.size()) begin
                n_checks++; if (rx0[i] !== tx0[i]) begin n_fail++; $display("FAIL il_order0[%0d]: got %h expected %h", i, rx0[i], tx0[i]); end
            end
            if (i < rx1.size()) begin
                n_checks++; if (rx1[i] !== tx1[i]) begin n_fail++; $display("FAIL il_order1[%0d]: got %h expected %h", i, rx1[i], tx1[i]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 64'h10, 1'b0); commit();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 64'h11, 1'b0); commit();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 64'h20, 1'b0); commit();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 64'h21, 1'b0); commit();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 64'h99, 1'b1);
        n_checks++; if (vc_full !== 2'b11) begin n_fail++; $display("FAIL mid_prefull: got %b expected 11", vc_full); end
        commit();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, i[0], 1'b0, 1'b0, 64'h0, 1'b1);
            n_checks++; if (send_out !== 1'b0 || data_out !== 64'h0) begin n_fail++; $display("FAIL mid_stale%0d: got %b/%h expected 0/0", i, send_out, data_out); end
            n_checks++; if (vc_empty !== 2'b11 || vc_full !== 2'b00 || overflow !== 1'b0) begin n_fail++; $display("FAIL mid_flags%0d: got e%b f%b o%b expected e11 f00 o0", i, vc_empty, vc_full, overflow); end
            commit();
        end
    endtask

    initial begin
        reset = 1'b1; polarity = 1'b0; wr_en = 1'b0; wr_vc = 1'b0; wr_data = 64'h0; ready_in = 1'b0;
        m_ovf = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_single_flit();
        test_backpressure();
        test_overflow();
        test_interleave_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
